// File: rtl/arbitro_calculo.sv
// Round-robin arbiter granting two requesters access to one shared multi-cycle datapath.
// Latency: ack and dp_inicio on the grant edge; done one cycle after dp_pronto is sampled, or after TIMEOUT RUN cycles.
// Backpressure: a request waits, unlatched, while the datapath is busy; a dropped request is forgotten.
//
// Ports:
//   clk, rst (async active-low)
//   req0/req1, a*/b*/c* (W), k* (KW)         requester side: request level and operands
//   ack*/done*/err* (pulses), res* (W)       requester side: grant, completion, timeout, held result
//   dp_a/dp_b/dp_c (W), dp_k (KW)            latched operands to the shared datapath
//   dp_inicio, dp_clr, dp_pronto, dp_resultado   datapath start level, clear pulse, completion, result
module arbitro_calculo #(
    parameter int W       = 16,
    parameter int KW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  a0,
    input  logic [W-1:0]  b0,
    input  logic [W-1:0]  c0,
    input  logic [KW-1:0] k0,
    input  logic [W-1:0]  a1,
    input  logic [W-1:0]  b1,
    input  logic [W-1:0]  c1,
    input  logic [KW-1:0] k1,
    output logic          ack0,
    output logic          ack1,
    output logic          done0,
    output logic          done1,
    output logic          err0,
    output logic          err1,
    output logic [W-1:0]  res0,
    output logic [W-1:0]  res1,
    output logic [W-1:0]  dp_a,
    output logic [W-1:0]  dp_b,
    output logic [W-1:0]  dp_c,
    output logic [KW-1:0] dp_k,
    output logic          dp_inicio,
    output logic          dp_clr,
    input  logic          dp_pronto,
    input  logic [W-1:0]  dp_resultado
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;   // requester served most recently
    logic          gnt;    // requester owning the current operation
    logic          sel;    // requester that would win arbitration this cycle

    // On a tie the requester not served last wins; a lone request wins outright.
    always_comb begin
        sel = req1;
        if (req0 && req1) begin
            sel = ~last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            res0      <= '0;
            res1      <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            dp_k      <= '0;
            dp_inicio <= 1'b0;
            dp_clr    <= 1'b0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            dp_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= sel;
                        ack0      <= ~sel;
                        ack1      <= sel;
                        dp_a      <= sel ? a1 : a0;
                        dp_b      <= sel ? b1 : b0;
                        dp_c      <= sel ? c1 : c0;
                        dp_k      <= sel ? k1 : k0;
                        dp_inicio <= 1'b1;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (dp_pronto) begin
                        if (gnt) begin
                            res1 <= dp_resultado;
                        end else begin
                            res0 <= dp_resultado;
                        end
                        done0     <= ~gnt;
                        done1     <= gnt;
                        dp_inicio <= 1'b0;
                        state     <= FIN;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        if (gnt) begin
                            res1 <= '0;
                        end else begin
                            res0 <= '0;
                        end
                        done0     <= ~gnt;
                        done1     <= gnt;
                        err0      <= ~gnt;
                        err1      <= gnt;
                        dp_clr    <= 1'b1;
                        dp_inicio <= 1'b0;
                        state     <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    // done is visible during this cycle; the pointer moves now
                    // so the very next IDLE cycle already sees the new priority.
                    last  <= gnt;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_calculo.sv
module tb_arbitro_calculo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
    logic [7:0]  k0 = '0, k1 = '0;
    logic        ack0, ack1, done0, done1, err0, err1;
    logic [15:0] res0, res1, dp_a, dp_b, dp_c;
    logic [7:0]  dp_k;
    logic        dp_inicio, dp_clr, dp_pronto;
    logic [15:0] dp_resultado;

    // datapath model controls
    logic        model_en = 1'b1;
    logic        pronto_force = 1'b0;
    logic        pr;
    logic [3:0]  mcnt;

    int n_chk = 0;
    int n_pass = 0;
    int overlap = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    arbitro_calculo #(.W(16), .KW(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .c0(c0), .k0(k0),
        .a1(a1), .b1(b1), .c1(c1), .k1(k1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .res0(res0), .res1(res1),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_k(dp_k),
        .dp_inicio(dp_inicio), .dp_clr(dp_clr),
        .dp_pronto(dp_pronto), .dp_resultado(dp_resultado)
    );

    // Datapath model: dp_pronto rises 4 cycles after dp_inicio, result is the operand sum.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt <= '0;
            pr   <= 1'b0;
        end else if (dp_inicio && !pr) begin
            mcnt <= mcnt + 4'd1;
            pr   <= model_en && (mcnt == 4'd3);
        end else begin
            mcnt <= '0;
            pr   <= 1'b0;
        end
    end
    assign dp_pronto    = pr | pronto_force;
    assign dp_resultado = dp_a + dp_b + dp_c + {8'd0, dp_k};

    always @(negedge clk) begin
        if ((ack0 && ack1) || (done0 && done1) || (err0 && err1)) overlap++;
        if (done0 || done1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Waits for a grant, optionally drops the granted request, then waits for its done.
    task automatic do_txn(input bit drop, output int who, output int lat);
        int n;
        who = -1;
        lat = -1;
        n = 0;
        while (!(ack0 || ack1) && n < 40) begin @(negedge clk); n++; end
        if (!(ack0 || ack1)) begin chk("ack_wait", 0, 1); return; end
        who = ack1 ? 1 : 0;
        if (drop) begin
            if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        n = 0;
        while (!(done0 || done1) && n < 200) begin @(negedge clk); n++; end
        if (!(done0 || done1)) begin chk("done_wait", 0, 1); return; end
        lat = n;
        chk("done_owner", {31'd0, done1}, who);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    int who, lat, n, dc;
    int exp_order[4] = '{0, 1, 0, 1};

    initial begin
        // reset state
        #12;
        chk("rst_ack0", ack0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_inicio", dp_inicio, 0);
        chk("rst_clr", dp_clr, 0);
        chk("rst_res0", res0, 0);
        chk("rst_dpa", dp_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // single request, 3+4+6+8 = 21
        a0 = 16'd3; b0 = 16'd4; c0 = 16'd6; k0 = 8'd8;
        req0 = 1'b1;
        n = 0;
        while (!ack0 && n < 10) begin @(negedge clk); n++; end
        chk("t1_ack0", ack0, 1);
        chk("t1_ack1", ack1, 0);
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_inicio_c1", dp_inicio, 1);
        chk("t1_dpa", dp_a, 3);
        chk("t1_dpk", dp_k, 8);
        chk("t1_ack_pulse", ack0, 0);
        n = 1;
        while (!done0 && n < 40) begin @(negedge clk); n++; end
        chk("t1_latency", n, 5);
        chk("t1_done0", done0, 1);
        chk("t1_res0", res0, 21);
        chk("t1_err0", err0, 0);
        chk("t1_res1", res1, 0);
        chk("t1_inicio_fin", dp_inicio, 0);
        @(negedge clk);
        chk("t1_done_pulse", done0, 0);

        // simultaneous first requests after reset: requester 0 first
        do_reset();
        a1 = 16'd1; b1 = 16'd1; c1 = 16'd1; k1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        do_txn(1'b1, who, lat);
        chk("t2_first", who, 0);
        chk("t2_lat0", lat, 5);
        chk("t2_res0", res0, 21);
        do_txn(1'b1, who, lat);
        chk("t2_second", who, 1);
        chk("t2_res1", res1, 4);
        chk("t2_res0_held", res0, 21);

        // both held: alternating grants
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, who, lat);
            chk($sformatf("t3_grant%0d", i), who, exp_order[i]);
            chk($sformatf("t3_lat%0d", i), lat, 5);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // dp_pronto while idle must be ignored
        dc = done_cnt;
        pronto_force = 1'b1;
        @(negedge clk);
        pronto_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_done", done_cnt, dc);
        chk("t4_res0", res0, 21);
        chk("t4_res1", res1, 4);

        // timeout: datapath never completes
        model_en = 1'b0;
        req0 = 1'b1;
        do_txn(1'b1, who, lat);
        chk("t5_who", who, 0);
        chk("t5_latency", lat, 64);
        chk("t5_err0", err0, 1);
        chk("t5_err1", err1, 0);
        chk("t5_clr", dp_clr, 1);
        chk("t5_res0", res0, 0);
        chk("t5_inicio", dp_inicio, 0);
        @(negedge clk);
        chk("t5_err_pulse", err0, 0);
        chk("t5_clr_pulse", dp_clr, 0);
        model_en = 1'b1;

        // reset mid-RUN aborts silently, then normal service resumes
        a0 = 16'd2; b0 = 16'd2; c0 = 16'd2; k0 = 8'd2;
        req0 = 1'b1;
        n = 0;
        while (!ack0 && n < 10) begin @(negedge clk); n++; end
        chk("t6_ack0", ack0, 1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        dc = done_cnt;
        rst = 1'b0;
        #1;
        chk("t6_inicio", dp_inicio, 0);
        chk("t6_res1", res1, 0);
        chk("t6_dpa", dp_a, 0);
        chk("t6_ack0_rst", ack0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_done", done_cnt, dc);
        req0 = 1'b1;
        do_txn(1'b1, who, lat);
        chk("t6_who", who, 0);
        chk("t6_lat", lat, 5);
        chk("t6_res0", res0, 8);
        chk("t6_err0", err0, 0);

        @(negedge clk);
        chk("no_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
